// File: rtl/data_memory_hs.sv
// -----------------------------------------------------------------------------
// data_memory_hs
//
// Byte-addressable data memory for the load/store unit. It has a valid/ready
// request channel and a valid/ready response channel. Byte, halfword, word and
// doubleword accesses may start at any byte offset. An access that runs past
// the end of a row is split across two rows in a single cycle: each byte bank
// takes its own row address.
//
// Storage is NUM_BYTES independent banks, each DEPTH x 8, with synchronous
// write and a registered synchronous read.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset (FSM and response regs only)
//   req_valid     request present
//   req_ready     request accepted when req_valid && req_ready (IDLE only)
//   req_write     1 = store, 0 = load
//   req_addr      byte address
//   req_size      00 byte, 01 half, 10 word, 11 double
//   req_unsigned  load zero-extends when 1, sign-extends when 0
//   req_wdata     store data, LSB-aligned
//   resp_valid    response present
//   resp_ready    response consumed when resp_valid && resp_ready
//   resp_rdata    extended load data; 0 for stores and errors
//   resp_err      access rejected
//
// Optional feature macro: DATA_MEMORY_HS_MISALIGN_TRAP_EN
//   When defined, any access whose address is not a multiple of its size is
//   rejected with resp_err=1. When undefined, misaligned accesses complete
//   through the row-crossing path.
// -----------------------------------------------------------------------------
module data_memory_hs #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 2 ** (ADDR_W - $clog2(DATA_W / 8))
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int NUM_BYTES = DATA_W / 8;
    localparam int COL_W     = $clog2(NUM_BYTES);
    localparam int ROW_W     = ADDR_W - COL_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state_reg;

    logic             accept;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [3:0]       nbytes;
    logic             req_err;

    // Request-side information carried from the accept edge to the
    // response edge.
    logic [COL_W-1:0] col_reg;
    logic [1:0]       size_reg;
    logic             uns_reg;
    logic             write_reg;
    logic             err_reg;

    logic [7:0]        bank_q [NUM_BYTES];
    logic [DATA_W-1:0] rot_data;
    logic [DATA_W-1:0] ext_data;
    logic              fill;

    // Requests are ignored while reset is held, so nothing is written
    // during reset.
    assign accept = req_valid && req_ready && !reset;
    assign row    = req_addr[ADDR_W-1:COL_W];
    assign col    = req_addr[COL_W-1:0];
    assign nbytes = 4'd1 << req_size;

    always_comb begin
        req_err = 1'b0;
        if ((DATA_W == 32) && (req_size == 2'b11)) begin
            req_err = 1'b1;
        end
        // The top row has no next row. An access that would run past the
        // top row is rejected rather than wrapped to row 0.
        if ((row == ROW_W'(DEPTH - 1)) && ((int'(col) + int'(nbytes)) > NUM_BYTES)) begin
            req_err = 1'b1;
        end
`ifdef DATA_MEMORY_HS_MISALIGN_TRAP_EN
        // nbytes-1 gives the low address bits that must be zero for this
        // size. For a doubleword the 3-bit truncation of 8-1 is 3'b111.
        if ((req_addr[2:0] & 3'(nbytes - 4'd1)) != 3'b000) begin
            req_err = 1'b1;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Byte banks. Bank gi holds the bytes whose address is gi mod NUM_BYTES.
    // For an access starting at column col, request byte k maps to bank
    // (col+k) mod NUM_BYTES. When that wraps, which happens for banks below
    // col, the byte lies in the next row.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_bank
            localparam logic [COL_W-1:0] BANK = COL_W'(gi);

            logic [7:0]       mem [DEPTH];
            logic [7:0]       rd_reg;
            logic [COL_W-1:0] lane;
            logic [ROW_W-1:0] bank_row;
            logic             bank_we;
            logic [7:0]       bank_wd;

            // Request byte index that lands in this bank.
            assign lane     = BANK - col;
            assign bank_row = (BANK < col) ? (row + ROW_W'(1)) : row;
            assign bank_we  = accept && req_write && !req_err && (4'(lane) < nbytes);
            assign bank_wd  = req_wdata[8*lane +: 8];

            always_ff @(posedge clk) begin
                if (bank_we) begin
                    mem[bank_row] <= bank_wd;
                end
                if (accept) begin
                    rd_reg <= mem[bank_row];
                end
            end

            assign bank_q[gi] = rd_reg;
        end
    endgenerate

    // Undo the bank rotation so that request byte 0 sits in the LSB.
    always_comb begin
        rot_data = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            rot_data[8*k +: 8] = bank_q[COL_W'(k) + col_reg];
        end
    end

    // Truncate to the access size and extend upward.
    always_comb begin
        case (size_reg)
            2'b00:   fill = rot_data[7];
            2'b01:   fill = rot_data[15];
            2'b10:   fill = rot_data[31];
            default: fill = rot_data[DATA_W-1];
        endcase
        fill = fill & ~uns_reg;
        ext_data = '0;
        for (int b = 0; b < DATA_W; b++) begin
            ext_data[b] = (b < (8 << size_reg)) ? rot_data[b] : fill;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: IDLE -> WAIT -> RESP -> IDLE. All channel outputs are
    // registered.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            col_reg    <= '0;
            size_reg   <= 2'b00;
            uns_reg    <= 1'b0;
            write_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        col_reg   <= col;
                        size_reg  <= req_size;
                        uns_reg   <= req_unsigned;
                        write_reg <= req_write;
                        err_reg   <= req_err;
                        req_ready <= 1'b0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    resp_valid <= 1'b1;
                    resp_err   <= err_reg;
                    resp_rdata <= (err_reg || write_reg) ? '0 : ext_data;
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_hs.sv
// -----------------------------------------------------------------------------
// tb_data_memory_hs
//
// Directed and randomized checks of data_memory_hs (DATA_W=64, ADDR_W=20).
// The reference model is a flat byte-addressed array. Each access is handled
// directly: stores write bytes addr..addr+n-1, and loads gather and extend
// those bytes. An access is an error when it runs past the top of memory, or,
// when the misalign trap is built in, when addr is not a multiple of the
// access size.
// -----------------------------------------------------------------------------
module tb_data_memory_hs;

    localparam int DW = 64;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned ref_mem [int];

    always #5 clk = ~clk;

    data_memory_hs dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one access; updates the byte array for stores.
    function automatic void model(input bit wr, input int addr, input int size,
                                  input bit uns, input logic [63:0] wd,
                                  output logic [63:0] exp_d, output bit exp_e);
        int nb;
        nb    = 1 << size;
        exp_e = (addr + nb) > (1 << AW);
`ifdef DATA_MEMORY_HS_MISALIGN_TRAP_EN
        if ((addr % nb) != 0) exp_e = 1'b1;
`endif
        exp_d = '0;
        if (!exp_e) begin
            if (wr) begin
                for (int k = 0; k < nb; k++) ref_mem[addr + k] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < nb; k++) exp_d |= 64'(ref_mem[addr + k]) << (8 * k);
                if (!uns && nb < 8 && exp_d[8*nb-1])
                    exp_d |= ~((64'd1 << (8 * nb)) - 64'd1);
            end
        end
    endfunction

    // One full request/response exchange, starting just after a rising edge
    // in IDLE. The response is held back for 'hold' cycles before being
    // accepted.
    task automatic txn(input bit wr, input int addr, input int size, input bit uns,
                       input logic [63:0] wd, input int hold,
                       output logic [63:0] got_d, output bit got_e);
        logic [63:0] ed;
        bit          ee;
        model(wr, addr, size, uns, wd, ed, ee);
        chk("idle_req_ready", req_ready, 1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr[AW-1:0];
        req_size     = size[1:0];
        req_unsigned = uns;
        req_wdata    = wd;
        @(posedge clk); #1;
        // Junk on the request bus while not ready must be ignored.
        req_valid    = 1'($urandom);
        req_write    = 1'($urandom);
        req_addr     = AW'($urandom);
        req_wdata    = {$urandom, $urandom};
        chk("wait_req_ready", req_ready, 0);
        chk("wait_resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        got_d = resp_rdata;
        got_e = resp_err;
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", resp_valid, 1);
            chk("resp_rdata", resp_rdata, ed);
            chk("resp_err", resp_err, 64'(ee));
            chk("resp_req_ready", req_ready, 0);
            if (h < hold) begin
                @(posedge clk); #1;
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("done_resp_valid", resp_valid, 0);
        chk("done_req_ready", req_ready, 1);
    endtask

    initial begin
        logic [63:0] d;
        logic [63:0] ed;
        bit          e;
        bit          ee;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Give the regions used below known contents.
        for (int a = 0; a < 'h110; a += 8)
            txn(1, a, 3, 0, {$urandom, $urandom}, 0, d, e);
        for (int a = 'hFFF00; a < 'h100000; a += 8)
            txn(1, a, 3, 0, {$urandom, $urandom}, 0, d, e);

        // Doubleword across a row boundary.
        txn(1, 'h5, 3, 1, 64'h1122334455667788, 0, d, e);
        txn(0, 'h5, 3, 1, 64'h0, 0, d, e);
`ifndef DATA_MEMORY_HS_MISALIGN_TRAP_EN
        chk("dbl_cross_data", d, 64'h1122334455667788);
        chk("dbl_cross_err", 64'(e), 0);
`endif

        // Byte sign/zero extension.
        txn(1, 'h10, 0, 0, 64'h80, 0, d, e);
        txn(0, 'h10, 0, 0, 64'h0, 0, d, e);
        chk("byte_signed", d, 64'hFFFFFFFFFFFFFF80);
        txn(0, 'h10, 0, 1, 64'h0, 0, d, e);
        chk("byte_unsigned", d, 64'h0000000000000080);

        // Partial overwrite of a word.
        txn(1, 'h20, 2, 0, 64'hDEADBEEF, 0, d, e);
        txn(1, 'h22, 1, 0, 64'h1234, 0, d, e);
        txn(0, 'h20, 2, 1, 64'h0, 0, d, e);
        chk("word_merge", d, 64'h000000001234BEEF);

        // A top-row crossing store is rejected and writes nothing.
        txn(1, 'hFFFF8, 3, 0, 64'hCAFEF00D12345678, 0, d, e);
        txn(1, 'hFFFFE, 2, 0, 64'h55AA55AA, 0, d, e);
        chk("top_cross_err", 64'(e), 1);
        chk("top_cross_data", d, 0);
        txn(0, 'hFFFF8, 3, 1, 64'h0, 0, d, e);
        chk("top_unchanged", d, 64'hCAFEF00D12345678);

        // Response back-pressure: held for 5 cycles.
        txn(0, 'h20, 2, 1, 64'h0, 5, d, e);

        // Reset while a store is in WAIT.
        chk("rstmid_req_ready", req_ready, 1);
        model(1, 'h40, 0, 0, 64'hAB, ed, ee);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00040; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 64'hAB;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk("rstmid_resp_valid", resp_valid, 0);
        chk("rstmid_ready", req_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_resp_valid_after", resp_valid, 0);
        chk("rstmid_ready_after", req_ready, 1);
        txn(0, 'h40, 0, 1, 64'h0, 0, d, e);
        chk("rstmid_store_kept", d, 64'hAB);
`ifdef DATA_MEMORY_HS_MISALIGN_TRAP_EN
        txn(0, 'h41, 1, 1, 64'h0, 0, d, e);
        chk("misalign_half_err", 64'(e), 1);
`endif

        // Randomized accesses over the initialized windows.
        for (int i = 0; i < 120; i++) begin
            int a;
            if (($urandom % 4) == 0) a = 'hFFFE0 + int'($urandom % 32);
            else                     a = int'($urandom % 'h100);
            txn(1'($urandom), a, int'($urandom % 4), 1'($urandom),
                {$urandom, $urandom}, int'($urandom % 3), d, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
